peak_search: RTL and testbench

PEAK_SEARCH -- requirements
Module: peak_search

---
 rtl/peak_search_pkg.sv | 18 +
 rtl/peak_search_compare.sv | 78 +++++++
 rtl/peak_search.sv | 119 +++++++++++
 tb/tb_peak_search.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/peak_search_pkg.sv
// peak_search_pkg
//   Shared constants for the peak search block: the control FSM state
//   encodings and a helper that clamps the reported "empty frame" bin index.
//   No ports; imported by peak_search and peak_compare.
package peak_search_pkg;

  // Control FSM encodings, kept together with the other control encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Bin reported when nothing beats the initial running max of zero.
  // SKIP may exceed the frame, so the index is clamped to the last bin.
  function automatic int clamp_skip(input int skip, input int depth);
    return (skip > depth - 1) ? depth - 1 : skip;
  endfunction

endpackage

// File: rtl/peak_search_compare.sv
// peak_compare
//   Running max / running index / running above-threshold count datapath
//   for one frame of magnitude samples.
//   Ports:
//     clock, reset      rising-edge clock, async active-low reset
//     clear             start of frame: reload the running registers
//     sample_en         one sample consumed this cycle
//     mag, bin          sample value and its bin index
//     threshold         latched detection level
//     run_max/bin/count current running registers
//     nxt_max/bin/count values the running registers take at the next edge,
//                       so the parent can capture the final sample's effect
module peak_compare
  import peak_search_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 256,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int SKIP      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     mag,
  input  logic [DEPTH_LOG-1:0] bin,
  input  logic [WIDTH-1:0]     threshold,
  output logic [WIDTH-1:0]     run_max,
  output logic [DEPTH_LOG-1:0] run_bin,
  output logic [DEPTH_LOG:0]   run_count,
  output logic [WIDTH-1:0]     nxt_max,
  output logic [DEPTH_LOG-1:0] nxt_bin,
  output logic [DEPTH_LOG:0]   nxt_count
);

  localparam int CNT_W = DEPTH_LOG + 1;
  localparam logic [DEPTH_LOG-1:0] INIT_BIN = DEPTH_LOG'(clamp_skip(SKIP, DEPTH));

  logic in_skip;

  // Leading DC bins are consumed but never counted or considered as peaks
  assign in_skip = int'(bin) < SKIP;

  // Strict greater-than keeps the earliest bin on ties
  always_comb begin
    nxt_max   = run_max;
    nxt_bin   = run_bin;
    nxt_count = run_count;
    if (sample_en && !in_skip) begin
      if (mag > run_max) begin
        nxt_max = mag;
        nxt_bin = bin;
      end
      if (mag > threshold) begin
        nxt_count = run_count + CNT_W'(1);
      end
    end
  end

  // The clear value of the index is the clamped SKIP bin, so a frame with
  // no nonzero in-range sample reports peak 0 at that bin
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_max   <= '0;
      run_bin   <= '0;
      run_count <= '0;
    end else if (clear) begin
      run_max   <= '0;
      run_bin   <= INIT_BIN;
      run_count <= '0;
    end else begin
      run_max   <= nxt_max;
      run_bin   <= nxt_bin;
      run_count <= nxt_count;
    end
  end

endmodule

// File: rtl/peak_search.sv
// peak_search
//   Scans one frame of DEPTH magnitude bins and reports the largest
//   magnitude, its bin, and how many bins exceed a threshold.
//   Ports:
//     clock, reset   rising-edge clock, async active-low reset
//     start          single-cycle scan request (honoured only in IDLE)
//     mag, mag_valid magnitude sample stream
//     threshold      detection level, latched on the accepted start
//     busy           high in SCAN and FINISH
//     done           one-cycle pulse in FINISH, when results update
//     peak_mag, peak_bin, above_count  held frame results
module peak_search
  import peak_search_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 256,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int SKIP      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mag,
  input  logic                 mag_valid,
  input  logic [WIDTH-1:0]     threshold,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     peak_mag,
  output logic [DEPTH_LOG-1:0] peak_bin,
  output logic [DEPTH_LOG:0]   above_count
);

  localparam logic [DEPTH_LOG-1:0] LAST_BIN = DEPTH_LOG'(DEPTH - 1);

  logic [1:0]           state;
  logic [DEPTH_LOG-1:0] bin_cnt;
  logic [WIDTH-1:0]     thr_q;
  logic                 start_ok;
  logic                 accept;
  logic                 last;

  logic [WIDTH-1:0]     run_max;
  logic [DEPTH_LOG-1:0] run_bin;
  logic [DEPTH_LOG:0]   run_count;
  logic [WIDTH-1:0]     nxt_max;
  logic [DEPTH_LOG-1:0] nxt_bin;
  logic [DEPTH_LOG:0]   nxt_count;

  // start is only honoured in IDLE, which also covers the FINISH/done cycle
  assign start_ok = (state == ST_IDLE) && start;
  assign accept   = (state == ST_SCAN) && mag_valid;
  assign last     = accept && (bin_cnt == LAST_BIN);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state <= ST_SCAN;
        ST_SCAN:   if (last) state <= ST_FINISH;
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Bin counter holds at the last bin rather than wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
      thr_q   <= '0;
    end else if (start_ok) begin
      bin_cnt <= '0;
      thr_q   <= threshold;
    end else if (accept && !last) begin
      bin_cnt <= bin_cnt + DEPTH_LOG'(1);
    end
  end

  peak_compare #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG),
    .SKIP      (SKIP)
  ) u_compare (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_ok),
    .sample_en (accept),
    .mag       (mag),
    .bin       (bin_cnt),
    .threshold (thr_q),
    .run_max   (run_max),
    .run_bin   (run_bin),
    .run_count (run_count),
    .nxt_max   (nxt_max),
    .nxt_bin   (nxt_bin),
    .nxt_count (nxt_count)
  );

  // Results are captured on the edge that consumes the last bin, using the
  // running values that include that sample, so they are already valid in
  // the FINISH cycle while done is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_mag    <= '0;
      peak_bin    <= '0;
      above_count <= '0;
    end else if (last) begin
      peak_mag    <= nxt_max;
      peak_bin    <= nxt_bin;
      above_count <= nxt_count;
    end
  end

endmodule

// File: tb/tb_peak_search.sv
// tb_peak_search
//   Directed frames through peak_search (DEPTH=256, SKIP=1) with
//   hand-computed results, done timing, result hold and mid-scan reset.
module tb_peak_search;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] mag;
  logic        mag_valid;
  logic [15:0] threshold;
  logic        busy;
  logic        done;
  logic [15:0] peak_mag;
  logic [7:0]  peak_bin;
  logic [8:0]  above_count;

  logic [15:0] frame_mag [256];
  int          assert_count;
  int          fail_count;
  int          done_count;

  peak_search dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mag         (mag),
    .mag_valid   (mag_valid),
    .threshold   (threshold),
    .busy        (busy),
    .done        (done),
    .peak_mag    (peak_mag),
    .peak_bin    (peak_bin),
    .above_count (above_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count done pulses seen at rising edges
  always @(posedge clock) begin
    if (done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [15:0] e_mag,
                             input logic [7:0] e_bin, input logic [8:0] e_cnt);
    checkOutput({tag, "_peak_mag"}, 32'(peak_mag), 32'(e_mag));
    checkOutput({tag, "_peak_bin"}, 32'(peak_bin), 32'(e_bin));
    checkOutput({tag, "_above_count"}, 32'(above_count), 32'(e_cnt));
  endtask

  // Feeds frame_mag as one frame. gap_pct inserts idle cycles, restart_at
  // raises start alongside that bin, reset_at aborts the frame with a reset
  // at that bin, hold_at checks that the previous results are still held.
  task automatic applyStimulus(input logic [15:0] thr, input int gap_pct,
                               input int restart_at, input int reset_at,
                               input int hold_at, input logic [15:0] h_mag,
                               input logic [7:0] h_bin, input logic [8:0] h_cnt);
    int dc0;
    int gaps;
    @(negedge clock);
    start = 1'b1;
    threshold = thr;
    mag_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    threshold = ~thr;
    checkOutput("busy_scan", 32'(busy), 32'd1);
    dc0 = done_count;
    for (int i = 0; i < 256; i++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 8 && $urandom_range(99, 0) < gap_pct) begin
        mag_valid = 1'b0;
        mag = 16'hDEAD;
        @(negedge clock);
        gaps++;
      end
      if (i == reset_at) begin
        mag_valid = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkResult("rst", 16'd0, 8'd0, 9'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_no_done", 32'(done_count), 32'(dc0));
        return;
      end
      if (i == hold_at) checkResult("hold", h_mag, h_bin, h_cnt);
      mag_valid = 1'b1;
      mag = frame_mag[i];
      start = (i == restart_at);
      @(negedge clock);
      start = 1'b0;
      if (i == 254) checkOutput("no_early_done", 32'(done), 32'd0);
    end
    mag_valid = 1'b0;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_finish", 32'(busy), 32'd1);
    checkOutput("done_count_pre", 32'(done_count), 32'(dc0));
    @(negedge clock);
    checkOutput("done_low", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("one_done", 32'(done_count), 32'(dc0 + 1));
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    done_count   = 0;
    reset     = 1'b0;
    start     = 1'b0;
    mag       = '0;
    mag_valid = 1'b0;
    threshold = '0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkResult("reset", 16'd0, 8'd0, 9'd0);
    @(negedge clock);
    reset = 1'b1;

    // Ramp mag=bin, threshold 100: bins 101..255 exceed it
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'(i);
    applyStimulus(16'd100, 0, -1, -1, -1, '0, '0, '0);
    checkResult("ramp", 16'd255, 8'd255, 9'd155);

    // Huge DC bin is skipped
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'd5;
    frame_mag[0] = 16'hFFFF;
    applyStimulus(16'd10, 0, -1, -1, -1, '0, '0, '0);
    checkResult("dc_skip", 16'd5, 8'd1, 9'd0);

    // Tie at bins 40 and 90: lower bin wins; 10 is not above 10
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'd10;
    frame_mag[40] = 16'd300;
    frame_mag[90] = 16'd300;
    applyStimulus(16'd10, 0, -1, -1, -1, '0, '0, '0);
    checkResult("tie", 16'd300, 8'd40, 9'd2);

    // Back-to-back: tie results must hold throughout the ramp scan
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'(i);
    applyStimulus(16'd100, 0, -1, -1, 128, 16'd300, 8'd40, 9'd2);
    checkResult("b2b", 16'd255, 8'd255, 9'd155);

    // Descending ramp with random gaps and a stray start mid-scan;
    // bin0=255 skipped, bins 1..54 exceed 200
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'(255 - i);
    applyStimulus(16'd200, 50, 100, -1, -1, '0, '0, '0);
    checkResult("gaps", 16'd254, 8'd1, 9'd54);

    // Reset at bin 128 aborts the frame, then an all-zero frame
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'd77;
    applyStimulus(16'd0, 0, -1, 128, -1, '0, '0, '0);
    for (int i = 0; i < 256; i++) frame_mag[i] = 16'd0;
    applyStimulus(16'd0, 0, -1, -1, -1, '0, '0, '0);
    checkResult("zeros", 16'd0, 8'd1, 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
